// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC select plus PC / IF-ID control from hazards, branches and memory misses.
// Optional performance counters are enabled by defining PC_PERF_CNT_EN.
module pc_sequencer #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BOOT_CYC  = 4,
    parameter int unsigned MAX_STALL = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              hazard_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_tgt_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_tgt_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              pc_start_o,
    output logic              pc_stall_o,
    output logic              pc_hold_o,
    output logic              ifid_hold_o,
    output logic              flush_o,
    output logic              busy_o,
    output logic              timeout_o
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cyc_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int unsigned BOOT_W  = $clog2(BOOT_CYC + 1);
    localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_BOOT     = 2'd1,
        S_RUN      = 2'd2,
        S_MEM_WAIT = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BOOT_W-1:0]    boot_cnt;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 ack_seen;

    // State register, boot/stall counters and sticky timeout
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_OFF;
            boot_cnt  <= '0;
            stall_cnt <= '0;
            timeout_o <= 1'b0;
            ack_seen  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == S_BOOT && start_i)
                boot_cnt <= boot_cnt + BOOT_W'(1);
            else
                boot_cnt <= '0;

            if (state == S_MEM_WAIT && start_i) begin
                if (stall_cnt != STALL_W'(MAX_STALL))
                    stall_cnt <= stall_cnt + STALL_W'(1);
                if (stall_cnt >= STALL_W'(MAX_STALL - 1))
                    timeout_o <= 1'b1;
            end else begin
                stall_cnt <= '0;
            end

            if (state == S_OFF)
                timeout_o <= 1'b0;

            // An ack arriving together with the miss completes the access early
            ack_seen <= (state == S_RUN) && mem_req_i && mem_ack_i;
        end
    end

    // Next-state and combinational PC / IF-ID controls
    always_comb begin
        state_nxt   = state;
        pc_next_o   = pc_plus4_i;
        pc_start_o  = 1'b0;
        pc_stall_o  = 1'b0;
        pc_hold_o   = 1'b1;
        ifid_hold_o = 1'b1;
        flush_o     = 1'b0;
        busy_o      = 1'b0;

        case (state)
            S_OFF: begin
                if (start_i)
                    state_nxt = S_BOOT;
            end
            S_BOOT: begin
                busy_o = 1'b1;
                if (!start_i)
                    state_nxt = S_OFF;
                else if (boot_cnt == BOOT_W'(BOOT_CYC - 1))
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                pc_start_o = 1'b1;
                if (!start_i)
                    state_nxt = S_OFF;
                else if (mem_req_i)
                    state_nxt = S_MEM_WAIT;

                if (mem_req_i) begin
                    pc_stall_o = 1'b1;
                    pc_hold_o  = 1'b0;
                end else if (hazard_i) begin
                    pc_hold_o   = 1'b1;
                    ifid_hold_o = 1'b1;
                end else if (branch_i) begin
                    pc_next_o   = branch_tgt_i;
                    flush_o     = 1'b1;
                    pc_hold_o   = 1'b0;
                    ifid_hold_o = 1'b0;
                end else if (jump_i) begin
                    pc_next_o   = jump_tgt_i;
                    flush_o     = 1'b1;
                    pc_hold_o   = 1'b0;
                    ifid_hold_o = 1'b0;
                end else begin
                    pc_hold_o   = 1'b0;
                    ifid_hold_o = 1'b0;
                end
            end
            S_MEM_WAIT: begin
                pc_start_o = 1'b1;
                pc_stall_o = 1'b1;
                pc_hold_o  = 1'b0;
                busy_o     = 1'b1;
                if (!start_i)
                    state_nxt = S_OFF;
                else if (mem_ack_i || ack_seen)
                    state_nxt = S_RUN;
            end
            default: state_nxt = S_OFF;
        endcase
    end

`ifdef PC_PERF_CNT_EN
    logic active;
    assign active = (state == S_RUN) || (state == S_MEM_WAIT);

    // Free-running performance counters, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cyc_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (active && (pc_stall_o || pc_hold_o))
                stall_cyc_o <= stall_cyc_o + 32'd1;
            if (flush_o)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; define PC_PERF_CNT_EN to include the counter checks.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        hazard_i;
    logic        branch_i;
    logic [31:0] branch_tgt_i;
    logic        jump_i;
    logic [31:0] jump_tgt_i;
    logic [31:0] pc_plus4_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic [31:0] pc_next_o;
    logic        pc_start_o;
    logic        pc_stall_o;
    logic        pc_hold_o;
    logic        ifid_hold_o;
    logic        flush_o;
    logic        busy_o;
    logic        timeout_o;
`ifdef PC_PERF_CNT_EN
    logic [31:0] stall_cyc_o;
    logic [31:0] flush_cnt_o;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    pc_sequencer #(.ADDR_W(32), .BOOT_CYC(4), .MAX_STALL(255)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .hazard_i     (hazard_i),
        .branch_i     (branch_i),
        .branch_tgt_i (branch_tgt_i),
        .jump_i       (jump_i),
        .jump_tgt_i   (jump_tgt_i),
        .pc_plus4_i   (pc_plus4_i),
        .mem_req_i    (mem_req_i),
        .mem_ack_i    (mem_ack_i),
        .pc_next_o    (pc_next_o),
        .pc_start_o   (pc_start_o),
        .pc_stall_o   (pc_stall_o),
        .pc_hold_o    (pc_hold_o),
        .ifid_hold_o  (ifid_hold_o),
        .flush_o      (flush_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
`ifdef PC_PERF_CNT_EN
        ,
        .stall_cyc_o  (stall_cyc_o),
        .flush_cnt_o  (flush_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(pc_start_o), 32'd0);
        chk({tag, "_stall"}, 32'(pc_stall_o), 32'd0);
        chk({tag, "_hold"},  32'(pc_hold_o),  32'd1);
        chk({tag, "_ifid"},  32'(ifid_hold_o), 32'd1);
        chk({tag, "_flush"}, 32'(flush_o),    32'd0);
        chk({tag, "_busy"},  32'(busy_o),     32'd0);
        chk({tag, "_tmo"},   32'(timeout_o),  32'd0);
        chk({tag, "_next"},  pc_next_o,       32'h1004);
    endtask

    // Release reset with start high and walk through BOOT into RUN
    task automatic boot_to_run(input string tag);
        cyc();
        rst_i   = 1'b1;
        start_i = 1'b1;
        #1;
        chk({tag, "_off_start"}, 32'(pc_start_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk({tag, "_boot_start"}, 32'(pc_start_o), 32'd0);
            chk({tag, "_boot_busy"},  32'(busy_o),     32'd1);
            chk({tag, "_boot_hold"},  32'(pc_hold_o),  32'd1);
        end
        cyc();
        #1;
        chk({tag, "_run_start"}, 32'(pc_start_o), 32'd1);
        chk({tag, "_run_hold"},  32'(pc_hold_o),  32'd0);
        chk({tag, "_run_next"},  pc_next_o,       32'h1004);
        chk({tag, "_run_busy"},  32'(busy_o),     32'd0);
    endtask

    initial begin
        rst_i        = 1'b0;
        start_i      = 1'b0;
        hazard_i     = 1'b0;
        branch_i     = 1'b0;
        jump_i       = 1'b0;
        mem_req_i    = 1'b0;
        mem_ack_i    = 1'b0;
        pc_plus4_i   = 32'h1004;
        branch_tgt_i = 32'h40;
        jump_tgt_i   = 32'h80;
        #2;
        chk_reset_vals("rst");

        boot_to_run("boot");

        // Branch, branch+jump, jump
        branch_i = 1'b1; #1;
        chk("br_next",  pc_next_o,        32'h40);
        chk("br_flush", 32'(flush_o),     32'd1);
        cyc(); branch_i = 1'b0; #1;
        chk("br_flush_end", 32'(flush_o), 32'd0);
        chk("br_next_end",  pc_next_o,    32'h1004);
        cyc(); branch_i = 1'b1; jump_i = 1'b1; #1;
        chk("brj_next", pc_next_o,        32'h40);
        chk("brj_flush", 32'(flush_o),    32'd1);
        cyc(); branch_i = 1'b0; #1;
        chk("jmp_next", pc_next_o,        32'h80);
        chk("jmp_flush", 32'(flush_o),    32'd1);
        cyc(); jump_i = 1'b0; #1;

        // Hazard masks a branch, branch taken once hazard clears
        hazard_i = 1'b1; branch_i = 1'b1; #1;
        chk("hz_hold",  32'(pc_hold_o),   32'd1);
        chk("hz_ifid",  32'(ifid_hold_o), 32'd1);
        chk("hz_flush", 32'(flush_o),     32'd0);
        chk("hz_next",  pc_next_o,        32'h1004);
        cyc(); hazard_i = 1'b0; #1;
        chk("hz_br_next",  pc_next_o,     32'h40);
        chk("hz_br_flush", 32'(flush_o),  32'd1);
        chk("hz_br_hold",  32'(pc_hold_o), 32'd0);
        cyc(); branch_i = 1'b0; #1;

        // Miss acked after 10 cycles
        mem_req_i = 1'b1; #1;
        chk("mr_stall", 32'(pc_stall_o),  32'd1);
        chk("mr_ifid",  32'(ifid_hold_o), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 10) begin
                mem_ack_i = 1'b1;
                mem_req_i = 1'b0;
            end
            #1;
            chk("mw_stall", 32'(pc_stall_o), 32'd1);
            chk("mw_busy",  32'(busy_o),     32'd1);
            chk("mw_start", 32'(pc_start_o), 32'd1);
        end
        cyc(); mem_ack_i = 1'b0; #1;
        chk("mw_ret_stall", 32'(pc_stall_o), 32'd0);
        chk("mw_ret_busy",  32'(busy_o),     32'd0);
        chk("mw_ret_hold",  32'(pc_hold_o),  32'd0);

        // Ack on the first MEM_WAIT cycle
        mem_req_i = 1'b1;
        cyc(); mem_req_i = 1'b0; mem_ack_i = 1'b1; #1;
        chk("ack0_stall", 32'(pc_stall_o), 32'd1);
        cyc(); mem_ack_i = 1'b0; #1;
        chk("ack0_ret", 32'(pc_stall_o), 32'd0);

        // No ack: timeout after 255 MEM_WAIT cycles, then sticky
        mem_req_i = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            cyc();
            #1;
            if (k == 255)
                chk("tmo_before", 32'(timeout_o), 32'd0);
        end
        cyc(); #1;
        chk("tmo_set",  32'(timeout_o), 32'd1);
        chk("tmo_busy", 32'(busy_o),    32'd1);
        mem_ack_i = 1'b1; mem_req_i = 1'b0;
        cyc(); mem_ack_i = 1'b0; #1;
        chk("tmo_sticky", 32'(timeout_o),  32'd1);
        chk("tmo_run",    32'(pc_stall_o), 32'd0);

        // Async reset in MEM_WAIT
        mem_req_i = 1'b1;
        cyc(); mem_req_i = 1'b0; #2;
        chk("pre_rst_stall", 32'(pc_stall_o), 32'd1);
        rst_i = 1'b0; #1;
        chk_reset_vals("mid_rst");

        // start_i low in RUN returns to OFF
        boot_to_run("reboot");
        start_i = 1'b0;
        cyc(); #1;
        chk("off_start", 32'(pc_start_o), 32'd0);
        chk("off_busy",  32'(busy_o),     32'd0);
        chk("off_hold",  32'(pc_hold_o),  32'd1);

`ifdef PC_PERF_CNT_EN
        rst_i = 1'b0; #1;
        chk("perf_rst_stall", stall_cyc_o, 32'd0);
        chk("perf_rst_flush", flush_cnt_o, 32'd0);
        boot_to_run("perf");
        for (int i = 0; i < 3; i++) begin
            branch_i = 1'b1;
            cyc();
            branch_i = 1'b0;
            cyc();
        end
        hazard_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        hazard_i = 1'b0;
        cyc(); #1;
        chk("perf_flush", flush_cnt_o, 32'd3);
        chk("perf_stall", stall_cyc_o, 32'd5);
        start_i = 1'b0;
        cyc(); cyc(); #1;
        chk("perf_off_keep", flush_cnt_o, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
